proj_readin_router: RTL and testbench

// - Parametrised read-in router for projections arriving from the neighbouring sector via an FWFT FIFO.
// - Pops the FIFO, decodes seed tag / layer-disk flag / region bit, and drives one write strobe plus write address per memory channel.
// - Tracks BX boundaries and reports the closed BX; per-BX address counters with saturation and drop handling.
// - Sits between the inter-sector link FIFO and the projection memories feeding the match engines.

---
 rtl/proj_readin_router.sv | 179 +++++++++++++++++
 tb/tb_proj_readin_router.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proj_readin_router.sv
// Read-in router: pops projection words from an FWFT FIFO and writes them to per-channel memories.
// Optional drop counter is built when PROJ_ROUTER_DROP_CNT_EN is defined.
module proj_readin_router #(
  parameter int unsigned DATA_W      = 55,
  parameter int unsigned PAYLOAD_W   = 51,
  parameter int unsigned TAG_LSB     = 51,
  parameter int unsigned NCH         = 8,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned BX_W        = 4,
  parameter int unsigned LYR_IN_BIT  = 34,
  parameter int unsigned LYR_OUT_BIT = 33,
  parameter int unsigned DSK_BIT     = 25,
  parameter logic [3*NCH-1:0] CH_TAG    = '0,
  parameter logic [3*NCH-1:0] CH_MASK   = {NCH{3'b111}},
  parameter logic [NCH-1:0]   CH_DISK   = '0,
  parameter logic [NCH-1:0]   CH_OUTER  = '0,
  parameter logic [NCH-1:0]   CH_REGION = '0,
  parameter logic [NCH-1:0]   CH_ENABLE = '1,
  parameter logic [2:0]       IDX_DEFAULT = 3'b111,
  parameter logic [2:0]       IDX_ALT     = 3'b101,
  parameter logic [DATA_W-TAG_LSB-1:0] ALT_MATCH = 4'b1011
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    data_valid,
  input  logic                    new_bx,
  input  logic [BX_W-1:0]         bx_in,
  output logic                    fifo_rd_en,
  output logic [PAYLOAD_W+2:0]    data_out,
  output logic [NCH-1:0]          wr_en,
  output logic [NCH*ADDR_W-1:0]   wr_addr,
  output logic [BX_W-1:0]         output_BX,
  output logic                    send_BX,
  output logic [NCH-1:0]          overflow,
  output logic [15:0]             drop_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e state_q, state_d;
  logic   drain_q;
  logic   bx_close;
  logic [BX_W-1:0] cur_bx_q, next_bx_q, output_bx_q;
  logic   send_q;

  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic              s1_disk;
  logic [2:0]        s1_tag;
  logic [2:0]        prefix;
  logic [NCH-1:0]    rbit, hit, write, drop;

  logic [NCH-1:0][ADDR_W-1:0] cnt_q, wr_addr_q;
  logic [NCH-1:0]             full_q, ovf_q, wr_en_q;
  logic [PAYLOAD_W+2:0]       data_out_q;

  // Second DRAIN cycle: in-flight words have retired, so the BX can be closed.
  assign bx_close = (state_q == StDrain) && drain_q;

  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    unique case (state_q)
      StIdle:  if (new_bx) state_d = StRun;
      StRun: begin
        fifo_rd_en = data_valid & ~new_bx;
        if (new_bx) state_d = StDrain;
      end
      StDrain: if (drain_q) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      drain_q     <= 1'b0;
      cur_bx_q    <= '0;
      next_bx_q   <= '0;
      output_bx_q <= '0;
      send_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= (state_q == StDrain) ? ~drain_q : 1'b0;
      send_q  <= bx_close;
      if (new_bx && (state_q != StIdle)) next_bx_q <= bx_in;
      if (new_bx && (state_q == StIdle)) begin
        cur_bx_q <= bx_in;
      end else if (bx_close) begin
        output_bx_q <= cur_bx_q;
        cur_bx_q    <= new_bx ? bx_in : next_bx_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= fifo_rd_en;
      if (fifo_rd_en) s1_data_q <= data_in;
    end
  end

  assign s1_disk = s1_data_q[DATA_W-1];
  assign s1_tag  = s1_data_q[TAG_LSB +: 3];
  assign prefix  = (s1_data_q[DATA_W-1:TAG_LSB] == ALT_MATCH) ? IDX_ALT : IDX_DEFAULT;

  always_comb begin
    rbit  = '0;
    hit   = '0;
    write = '0;
    drop  = '0;
    for (int i = 0; i < NCH; i++) begin
      rbit[i] = s1_disk     ? s1_data_q[DSK_BIT] :
                CH_OUTER[i] ? s1_data_q[LYR_OUT_BIT] : s1_data_q[LYR_IN_BIT];
      hit[i]  = s1_valid_q & CH_ENABLE[i] & (s1_disk == CH_DISK[i]) &
                (((s1_tag ^ CH_TAG[3*i +: 3]) & CH_MASK[3*i +: 3]) == 3'b000) &
                (rbit[i] == CH_REGION[i]);
      write[i] = hit[i] & ~full_q[i];
      drop[i]  = hit[i] & full_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      full_q     <= '0;
      ovf_q      <= '0;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      data_out_q <= '0;
    end else begin
      wr_en_q <= write;
      if (s1_valid_q) data_out_q <= {prefix, s1_data_q[PAYLOAD_W-1:0]};
      if (bx_close) begin
        cnt_q  <= '0;
        full_q <= '0;
        ovf_q  <= '0;
      end else begin
        for (int i = 0; i < NCH; i++) begin
          if (write[i]) begin
            wr_addr_q[i] <= cnt_q[i];
            // Last slot written: counter holds, later hits become drops.
            if (cnt_q[i] == '1) full_q[i] <= 1'b1;
            else                cnt_q[i]  <= cnt_q[i] + 1'b1;
          end
          if (drop[i]) ovf_q[i] <= 1'b1;
        end
      end
    end
  end

`ifdef PROJ_ROUTER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if ((|drop) && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 16'd0;
`endif

  assign data_out  = data_out_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign output_BX = output_bx_q;
  assign send_BX   = send_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_proj_readin_router.sv
// Directed bench for proj_readin_router: each task drives one scenario and checks a cycle log.
module tb_proj_readin_router;

  localparam logic [23:0] TB_TAG  = {15'd0, 3'b100, 3'b000, 3'b010, 3'b100};
  localparam logic [23:0] TB_MASK = {{5{3'b111}}, 3'b111, 3'b100, 3'b111, 3'b111};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [54:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        new_bx = 1'b0;
  logic [3:0]  bx_in = '0;
  logic        fifo_rd_en;
  logic [53:0] data_out;
  logic [7:0]  wr_en;
  logic [47:0] wr_addr;
  logic [3:0]  output_BX;
  logic        send_BX;
  logic [7:0]  overflow;
  logic [15:0] drop_count;

  proj_readin_router #(
    .CH_TAG   (TB_TAG),
    .CH_MASK  (TB_MASK),
    .CH_DISK  (8'b0000_0110),
    .CH_OUTER (8'b0000_1000),
    .CH_REGION(8'b0000_1110),
    .CH_ENABLE(8'b0000_1111)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .data_valid(data_valid),
    .new_bx    (new_bx),
    .bx_in     (bx_in),
    .fifo_rd_en(fifo_rd_en),
    .data_out  (data_out),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .output_BX (output_BX),
    .send_BX   (send_BX),
    .overflow  (overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_log = 0;

  logic [54:0] fifo_q[$];
  logic        lg_rd   [256];
  logic [7:0]  lg_wr   [256];
  logic [47:0] lg_addr [256];
  logic        lg_send [256];
  logic [3:0]  lg_obx  [256];
  logic [7:0]  lg_ovf  [256];
  logic [15:0] lg_dc   [256];
  logic [53:0] lg_dout [256];

  function automatic logic [54:0] mk(input logic disk, input logic [2:0] tag, input logic b34,
                                     input logic b33, input logic b25, input logic [15:0] id);
    logic [54:0] w;
    w = '0;
    w[54] = disk;
    w[53:51] = tag;
    w[34] = b34;
    w[33] = b33;
    w[25] = b25;
    w[15:0] = id;
    return w;
  endfunction

  task automatic refresh();
    data_valid = (fifo_q.size() > 0);
    data_in    = data_valid ? fifo_q[0] : '0;
  endtask

  // Log this cycle's outputs, then advance one clock; inputs change only at negedge.
  task automatic tick();
    logic        rd;
    logic [54:0] junk;
    if (n_log < 256) begin
      lg_rd[n_log]   = fifo_rd_en;
      lg_wr[n_log]   = wr_en;
      lg_addr[n_log] = wr_addr;
      lg_send[n_log] = send_BX;
      lg_obx[n_log]  = output_BX;
      lg_ovf[n_log]  = overflow;
      lg_dc[n_log]   = drop_count;
      lg_dout[n_log] = data_out;
      n_log++;
    end
    rd = fifo_rd_en;
    @(posedge clk);
    if (rd && fifo_q.size() > 0) junk = fifo_q.pop_front();
    @(negedge clk);
    new_bx = 1'b0;
    refresh();
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    if (fifo_rd_en !== 1'b0 || wr_en !== 8'h00 || send_BX !== 1'b0 || overflow !== 8'h00) begin
      bad++;
      $display("FAIL reset_ctrl: rd=%b wr=%h send=%b ovf=%h want 0", fifo_rd_en, wr_en, send_BX,
               overflow);
    end
    total++;
    if (data_out !== '0 || wr_addr !== '0 || output_BX !== '0 || drop_count !== '0) begin
      bad++;
      $display("FAIL reset_data: dout=%h addr=%h obx=%h dc=%h want 0", data_out, wr_addr,
               output_BX, drop_count);
    end
    total++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int b;
    logic [54:0] w[3];
    b = n_log;
    for (int k = 0; k < 3; k++) begin
      w[k] = mk(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 16'h0100 + 16'(k));
      fifo_q.push_back(w[k]);
    end
    refresh();
    new_bx = 1'b1;
    bx_in  = 4'd3;
    #1;
    for (int k = 0; k < 7; k++) tick();
    if (lg_rd[b] !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle_rd: got %b want 0", lg_rd[b]);
    end
    total++;
    for (int k = 0; k < 3; k++) begin
      if (lg_wr[b+3+k] !== 8'h01 || lg_addr[b+3+k][5:0] !== 6'(k)) begin
        bad++;
        $display("FAIL basic_write%0d: wr=%h addr=%0d want wr=01 addr=%0d", k, lg_wr[b+3+k],
                 lg_addr[b+3+k][5:0], k);
      end
      total++;
    end
    if (lg_wr[b+6] !== 8'h00) begin
      bad++;
      $display("FAIL basic_tail: wr=%h want 00", lg_wr[b+6]);
    end
    total++;
    if (lg_dout[b+3] !== {3'b111, w[0][50:0]}) begin
      bad++;
      $display("FAIL basic_dout: got %h want %h", lg_dout[b+3], {3'b111, w[0][50:0]});
    end
    total++;
  endtask

  task automatic test_bx_close();
    int b;
    b = n_log;
    fifo_q.push_back(mk(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 16'h0200));
    fifo_q.push_back(mk(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 16'h0201));
    refresh();
    #1;
    tick();
    new_bx = 1'b1;
    bx_in  = 4'd4;
    #1;
    for (int k = 0; k < 6; k++) tick();
    if (lg_rd[b] !== 1'b1 || lg_rd[b+1] !== 1'b0 || lg_rd[b+2] !== 1'b0 || lg_rd[b+3] !== 1'b0)
    begin
      bad++;
      $display("FAIL close_rd: rd c0..c3=%b%b%b%b want 1000", lg_rd[b], lg_rd[b+1], lg_rd[b+2],
               lg_rd[b+3]);
    end
    total++;
    if (lg_wr[b+2] !== 8'h01 || lg_addr[b+2][5:0] !== 6'd3) begin
      bad++;
      $display("FAIL close_inflight: wr=%h addr=%0d want wr=01 addr=3", lg_wr[b+2],
               lg_addr[b+2][5:0]);
    end
    total++;
    if (lg_send[b+3] !== 1'b0 || lg_send[b+4] !== 1'b1 || lg_send[b+5] !== 1'b0) begin
      bad++;
      $display("FAIL close_send: send c3..c5=%b%b%b want 010", lg_send[b+3], lg_send[b+4],
               lg_send[b+5]);
    end
    total++;
    if (lg_obx[b+4] !== 4'd3) begin
      bad++;
      $display("FAIL close_bx: output_BX=%0d want 3", lg_obx[b+4]);
    end
    total++;
    if (lg_rd[b+4] !== 1'b1 || lg_wr[b+6] !== 8'h01 || lg_addr[b+6][5:0] !== 6'd0) begin
      bad++;
      $display("FAIL close_newbx: rd=%b wr=%h addr=%0d want rd=1 wr=01 addr=0", lg_rd[b+4],
               lg_wr[b+6], lg_addr[b+6][5:0]);
    end
    total++;
  endtask

  task automatic test_multi();
    int b;
    logic [54:0] d1, d2;
    b  = n_log;
    d1 = mk(1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 16'h0301);
    d2 = mk(1'b1, 3'b011, 1'b0, 1'b0, 1'b1, 16'h0302);
    fifo_q.push_back(d1);
    fifo_q.push_back(d2);
    fifo_q.push_back(mk(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 16'h0303));
    fifo_q.push_back(mk(1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 16'h0304));
    refresh();
    #1;
    for (int k = 0; k < 7; k++) tick();
    if (lg_wr[b+2] !== 8'h06 || lg_addr[b+2][11:6] !== 6'd0 || lg_addr[b+2][17:12] !== 6'd0) begin
      bad++;
      $display("FAIL multi_both: wr=%h a1=%0d a2=%0d want wr=06 a1=0 a2=0", lg_wr[b+2],
               lg_addr[b+2][11:6], lg_addr[b+2][17:12]);
    end
    total++;
    if (lg_dout[b+2] !== {3'b111, d1[50:0]}) begin
      bad++;
      $display("FAIL multi_dout_default: got %h want %h", lg_dout[b+2], {3'b111, d1[50:0]});
    end
    total++;
    if (lg_wr[b+3] !== 8'h04 || lg_addr[b+3][17:12] !== 6'd1) begin
      bad++;
      $display("FAIL multi_mask: wr=%h a2=%0d want wr=04 a2=1", lg_wr[b+3], lg_addr[b+3][17:12]);
    end
    total++;
    if (lg_dout[b+3] !== {3'b101, d2[50:0]}) begin
      bad++;
      $display("FAIL multi_dout_alt: got %h want %h", lg_dout[b+3], {3'b101, d2[50:0]});
    end
    total++;
    if (lg_wr[b+4] !== 8'h00) begin
      bad++;
      $display("FAIL multi_region_miss: wr=%h want 00", lg_wr[b+4]);
    end
    total++;
    if (lg_wr[b+5] !== 8'h09 || lg_addr[b+5][5:0] !== 6'd1 || lg_addr[b+5][23:18] !== 6'd0) begin
      bad++;
      $display("FAIL multi_outer: wr=%h a0=%0d a3=%0d want wr=09 a0=1 a3=0", lg_wr[b+5],
               lg_addr[b+5][5:0], lg_addr[b+5][23:18]);
    end
    total++;
  endtask

  task automatic test_reset_mid();
    int b;
    b = n_log;
    for (int k = 0; k < 5; k++) fifo_q.push_back(mk(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 16'h0400 + 16'(k)));
    refresh();
    #1;
    for (int k = 0; k < 3; k++) tick();
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    #1;
    tick();
    tick();
    new_bx = 1'b1;
    bx_in  = 4'd7;
    #1;
    for (int k = 0; k < 6; k++) tick();
    if (lg_wr[b+2] !== 8'h01 || lg_addr[b+2][5:0] !== 6'd2) begin
      bad++;
      $display("FAIL rmid_pre: wr=%h addr=%0d want wr=01 addr=2", lg_wr[b+2], lg_addr[b+2][5:0]);
    end
    total++;
    if (lg_wr[b+3] !== '0 || lg_addr[b+3] !== '0 || lg_dout[b+3] !== '0 || lg_rd[b+3] !== 1'b0 ||
        lg_send[b+3] !== 1'b0 || lg_ovf[b+3] !== '0 || lg_obx[b+3] !== '0) begin
      bad++;
      $display("FAIL rmid_clear: wr=%h addr=%h dout=%h rd=%b want all 0", lg_wr[b+3],
               lg_addr[b+3], lg_dout[b+3], lg_rd[b+3]);
    end
    total++;
    for (int k = 4; k < 7; k++) begin
      if (lg_rd[b+k] !== 1'b0 || lg_wr[b+k] !== 8'h00) begin
        bad++;
        $display("FAIL rmid_idle%0d: rd=%b wr=%h want rd=0 wr=00", k, lg_rd[b+k], lg_wr[b+k]);
      end
      total++;
    end
    if (lg_wr[b+9] !== 8'h01 || lg_addr[b+9][5:0] !== 6'd0 ||
        lg_wr[b+10] !== 8'h01 || lg_addr[b+10][5:0] !== 6'd1) begin
      bad++;
      $display("FAIL rmid_resume: wr=%h/%h addr=%0d/%0d want 01/01 addr 0/1", lg_wr[b+9],
               lg_wr[b+10], lg_addr[b+9][5:0], lg_addr[b+10][5:0]);
    end
    total++;
  endtask

  task automatic test_saturation();
    int b;
    logic [15:0] exp_dc;
`ifdef PROJ_ROUTER_DROP_CNT_EN
    exp_dc = 16'd1;
`else
    exp_dc = 16'd0;
`endif
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    b = n_log;
    for (int k = 0; k < 65; k++) fifo_q.push_back(mk(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 16'(k)));
    refresh();
    new_bx = 1'b1;
    bx_in  = 4'd9;
    #1;
    for (int k = 0; k < 70; k++) tick();
    for (int k = 0; k < 64; k++) begin
      if (lg_wr[b+3+k] !== 8'h01 || lg_addr[b+3+k][5:0] !== 6'(k) || lg_ovf[b+3+k] !== 8'h00) begin
        bad++;
        $display("FAIL sat_write%0d: wr=%h addr=%0d ovf=%h want wr=01 addr=%0d ovf=00", k,
                 lg_wr[b+3+k], lg_addr[b+3+k][5:0], lg_ovf[b+3+k], k);
      end
      total++;
    end
    if (lg_wr[b+67] !== 8'h00 || lg_ovf[b+67] !== 8'h01) begin
      bad++;
      $display("FAIL sat_drop: wr=%h ovf=%h want wr=00 ovf=01", lg_wr[b+67], lg_ovf[b+67]);
    end
    total++;
    if (lg_dc[b+67] !== exp_dc || lg_dc[b+68] !== exp_dc || lg_dc[b+66] !== 16'd0) begin
      bad++;
      $display("FAIL sat_dropcnt: dc=%0d/%0d/%0d want 0/%0d/%0d", lg_dc[b+66], lg_dc[b+67],
               lg_dc[b+68], exp_dc, exp_dc);
    end
    total++;
    if (lg_ovf[b+68] !== 8'h01 || lg_addr[b+68][5:0] !== 6'd63) begin
      bad++;
      $display("FAIL sat_sticky: ovf=%h addr=%0d want ovf=01 addr=63", lg_ovf[b+68],
               lg_addr[b+68][5:0]);
    end
    total++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bx_close();
    test_multi();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
